mux_rr_arbiter_4: RTL
=====================

// Module: mux_rr_arbiter_4
// PURPOSE
//  Round-robin arbiter sharing one 4-to-1 output path between 4 requesters.
//  - Grants one requester at a time and drives the 2-bit select.
//  - Forwards the granted requester's data word to a single output.
//  - Sits in front of any 4-way mux resource; holds the grant until the owner releases it.
// PARAMETERS
//  DATA_W    1   width of each requester data word
//  MAX_HOLD  8   max cycles one owner keeps the grant (used only with ARB_TIMEOUT_EN); >=2
// PORTS
//  clk    in   1         single clock, rising edge
//  rst    in   1         asynchronous, active-high reset
//  req    in   4         request per requester, level; held high while owning
//  in     in   4*DATA_W  data; requester i occupies in[i*DATA_W +: DATA_W]
//  gnt    out  4         one-hot grant, registered; all-zero when idle
//  sel    out  2         index of the granted requester, registered
//  valid  out  1         high when any grant is active (== |gnt)
//  out    out  DATA_W    in[sel] when valid; 0 otherwise (combinational from in)
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, sel=0, valid=0, ptr=0, state=IDLE, hold_cnt=0; out=0.
//  Pointer ptr (2b): requester with highest priority; search order is ptr, ptr+1, ... wrapping mod 4.
//  FSM:
//   IDLE  - if |req: grant winner=first set req from ptr; ->BUSY; ptr<=winner+1.
//           Latency: req sampled at edge N -> gnt/sel/valid at edge N (visible for cycle N+1).
//   BUSY  - owner = sel. If req[sel]=1: hold gnt, sel unchanged.
//           If req[sel]=0 and other req pending: hand off at the same edge, no idle bubble;
//             winner = first set req from ptr (ptr already past old owner, so old owner is lowest).
//           If req[sel]=0 and no req: ->IDLE, gnt=0, valid=0, sel holds last value.
//  Fairness: each requester waits at most 3 ownership tenures.
//  Simultaneous: several reqs rising together -> only the ptr-ordered winner is granted.
//   Non-granted reqs wait; gnt is never multi-hot.
//  Owner re-raising req after release competes as lowest priority.
//  Non-owner req toggling during BUSY has no effect on gnt.
//  Reset mid-BUSY: gnt drops asynchronously; after release, arbitration restarts at ptr=0.
//  out mux: sel==0->in[0], 1->in[1], 2->in[2], 3->in[3]; forced to 0 when !valid.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - hold_cnt counts cycles in BUSY with the same owner.
//   - When hold_cnt==MAX_HOLD-1, req[sel]=1 and another req is pending, preempt:
//     grant passes to the next ptr-ordered winner at that edge; hold_cnt<=0.
//   - If no other req is pending, the owner keeps the grant and the counter saturates.
//   - hold_cnt resets to 0 on every new grant.
//  ARB_TIMEOUT_EN undefined: no counter; the owner holds the grant indefinitely while req[sel]=1.
// STRUCTURE
//  Package mux_arb_pkg:
//   - state localparams ST_IDLE=1'b0, ST_BUSY=1'b1
//   - N_REQ=4, SEL_W=2
//   - function first_from(req,ptr)
//  Sub-module rr_pick4: combinational; req[3:0], ptr[1:0] -> found, idx[1:0] (rotate, priority-encode, unrotate).
//  Top: FSM + ptr/sel/gnt registers + hold counter + output mux.
// TESTING
//  1 Reset: rst=1 with req=4'b1111 -> gnt=0, sel=0, valid=0, out=0; rst falls -> next edge gnt=4'b0001, sel=0.
//  2 Rotation: req=4'b1111, each owner holds 2 cycles then drops 1 cycle
//    -> grant order 0,1,2,3,0; no cycle with two gnt bits set.
//  3 Handoff: owner 1 drops req while req=4'b0100 pending
//    -> same edge gnt=4'b0100, sel=2, valid stays 1 (no bubble).
//  4 Data: gnt on 2, in = {4'hA,4'h5,4'hC,4'h3} (DATA_W=4) -> out=4'h5;
//    after all req=0 -> valid=0, out=0.
//  5 Async reset mid-BUSY: assert rst between edges while gnt=4'b1000
//    -> gnt=0 immediately; after release, req=4'b1010 -> gnt=4'b0010.
//  6 ARB_TIMEOUT_EN, MAX_HOLD=8: req0 held forever, req3 raised
//    -> owner 0 preempted after 8 cycles, gnt=4'b1000; run without macro -> owner 0 keeps gnt.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and the round-robin search helper for mux_rr_arbiter_4.
package mux_arb_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam int   N_REQ   = 4;
  localparam int   SEL_W   = 2;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } state_t;

  // Index of the first set bit of req, searching ptr, ptr+1, ... modulo N_REQ.
  function automatic logic [SEL_W-1:0] first_from(input logic [N_REQ-1:0] req,
                                                  input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] k;
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) idx = k;
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0, priority-encode,
// then rotate the index back.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign w_rot[gi] = req[SEL_W'(gi) + ptr];
    end
  endgenerate

  assign w_off = first_from(w_rot, '0);
  assign idx   = w_off + ptr;
  assign found = |req;
endmodule

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter owning a 4-to-1 data mux; grant is held until the owner drops req.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others are waiting.
module mux_rr_arbiter_4
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] in,
  output logic [N_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]        sel,
  output logic                    valid,
  output logic [DATA_W-1:0]       out
);
  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;

  logic [N_REQ-1:0]   w_owner_oh;
  logic [N_REQ-1:0]   w_pick_req;
  logic               w_owner_req;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic               w_take;
  logic               w_release;
  logic               w_expired;
  logic [DATA_W-1:0]  w_word [N_REQ];

  generate
    if (MAX_HOLD < 2) begin : g_max_hold_unsupported
      // A hold limit below 2 cycles is not a supported configuration.
    end
  endgenerate

  assign w_owner_oh  = N_REQ'(1) << r_sel;
  assign w_owner_req = req[r_sel];
  // While busy the owner is masked so a preemption can never re-pick it.
  assign w_pick_req  = (r_state == S_BUSY) ? (req & ~w_owner_oh) : req;

  rr_pick4 u_pick (
    .req   (w_pick_req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int               HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] r_hold_cnt;
  assign w_expired = (r_hold_cnt == HOLD_LAST);
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_take    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: w_take = w_found;
      S_BUSY: begin
        if (!w_owner_req) begin
          w_take    = w_found;
          w_release = !w_found;
        end else begin
          w_take    = w_expired && w_found;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      if (w_take) begin
        r_state <= S_BUSY;
        r_gnt   <= N_REQ'(1) << w_idx;
        r_sel   <= w_idx;
        r_ptr   <= w_idx + SEL_W'(1);
      end else if (w_release) begin
        r_state <= S_IDLE;
        r_gnt   <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      // Counter saturates at HOLD_LAST when nobody else is waiting.
      if (w_take)
        r_hold_cnt <= '0;
      else if (r_state == S_BUSY && !w_expired)
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
      assign w_word[gi] = in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = |r_gnt;
  assign out   = valid ? w_word[r_sel] : '0;
endmodule
